iter_spn_cipher: RTL and testbench

Parametrised iterative substitution–permutation block cipher core with valid/ready handshakes on both sides. Each accepted block runs ROUNDS rounds: round-key XOR, a 4-bit S-box layer and a bit permutation, with an on-the-fly key schedule and final key whitening. It replaces single-XOR encryption stages on datapaths between the ingress buffer and the egress packer, and adds a synchronous zeroize.

---
 rtl/iter_spn_cipher.sv | 150 +++++++++++++++
 tb/tb_iter_spn_cipher.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_spn_cipher.sv
// -----------------------------------------------------------------------------
// iter_spn_cipher
//
// Iterative substitution-permutation block cipher core. One block is accepted
// in IDLE, then ROUNDS rounds are executed at one round per clock: round-key
// XOR, 4-bit S-box on every nibble, 1-bit left rotate of the block. The round
// key evolves on the fly (rotate left by KEY_ROT, XOR the round counter into
// bits [7:0]); the final round output is whitened with the next round key.
// Key material is wiped when the last round completes; only the ciphertext
// is held until the downstream handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   clear      synchronous zeroize, overrides every other input
//   in_valid   block and key presented on data_in / key
//   in_ready   core idle and able to accept a block
//   data_in    plaintext block   [DATA_W-1:0]
//   key        cipher key        [DATA_W-1:0]
//   out_valid  data_out holds a ciphertext
//   out_ready  downstream accepts data_out
//   data_out   ciphertext, registered [DATA_W-1:0]
//   busy       rounds in progress
// -----------------------------------------------------------------------------
module iter_spn_cipher #(
   parameter int DATA_W  = 128,
   parameter int ROUNDS  = 10,
   parameter int KEY_ROT = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              busy
);

   localparam int         NIBBLES  = DATA_W / 4;
   localparam logic [7:0] LAST_RND = 8'(ROUNDS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t              fsm_q, fsm_d;
   logic [DATA_W-1:0] state_q, state_d;
   logic [DATA_W-1:0] rkey_q, rkey_d;
   logic [7:0]        rnd_q, rnd_d;
   logic [DATA_W-1:0] dout_q, dout_d;

   logic [DATA_W-1:0] mixed;   // state ^ round key
   logic [DATA_W-1:0] subst;   // after S-box layer
   logic [DATA_W-1:0] perm;    // after 1-bit rotate
   logic [DATA_W-1:0] knext;   // next round key

   function automatic logic [3:0] sbox(input logic [3:0] n);
      case (n)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
      endcase
   endfunction

   // Round datapath: one full round is combinational between state registers.
   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first so no
      // path through the block leaves it unassigned (which would infer a latch).
      subst = '0;
      mixed = state_q ^ rkey_q;
      for (int i = 0; i < NIBBLES; i++) begin
         subst[4*i +: 4] = sbox(mixed[4*i +: 4]);
      end
      perm  = {subst[DATA_W-2:0], subst[DATA_W-1]};
      knext = ((rkey_q << KEY_ROT) | (rkey_q >> (DATA_W - KEY_ROT)))
              ^ {{(DATA_W-8){1'b0}}, rnd_q};
   end

   // Next-state logic. clear wins over every state and over in_valid.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      rnd_d   = rnd_q;
      dout_d  = dout_q;
      if (clear) begin
         fsm_d   = IDLE;
         state_d = '0;
         rkey_d  = '0;
         rnd_d   = '0;
         dout_d  = '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  state_d = data_in;
                  rkey_d  = key;
                  rnd_d   = 8'd1;
                  fsm_d   = RUN;
               end
            end
            RUN: begin
               if (rnd_q == LAST_RND) begin
                  // Final whitening, then wipe key material.
                  dout_d  = perm ^ knext;
                  state_d = '0;
                  rkey_d  = '0;
                  fsm_d   = DONE;
               end else begin
                  state_d = perm;
                  rkey_d  = knext;
                  rnd_d   = rnd_q + 8'd1;
               end
            end
            DONE: begin
               if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rkey_q  <= '0;
         rnd_q   <= '0;
         dout_q  <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         rnd_q   <= rnd_d;
         dout_q  <= dout_d;
      end
   end

   // Status outputs are pure decodes of the FSM register.
   assign in_ready  = (fsm_q == IDLE);
   assign busy      = (fsm_q == RUN);
   assign out_valid = (fsm_q == DONE);
   assign data_out  = dout_q;

endmodule

// File: tb/tb_iter_spn_cipher.sv
// -----------------------------------------------------------------------------
// tb_iter_spn_cipher
//
// Directed bench for iter_spn_cipher with DATA_W=16, KEY_ROT=13. Instance a
// runs ROUNDS=1, instance b runs ROUNDS=2. Inputs change and outputs are
// sampled on the falling edge; expected ciphertexts are worked out by hand.
// -----------------------------------------------------------------------------
module tb_iter_spn_cipher;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [15:0] a_data_in, a_key, a_data_out;
   logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [15:0] b_data_in, b_key, b_data_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iter_spn_cipher #(.DATA_W(16), .ROUNDS(1), .KEY_ROT(13)) dut_a (
      .clk(clk), .rst(rst), .clear(a_clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .data_in(a_data_in), .key(a_key),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .data_out(a_data_out), .busy(a_busy)
   );

   iter_spn_cipher #(.DATA_W(16), .ROUNDS(2), .KEY_ROT(13)) dut_b (
      .clk(clk), .rst(rst), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .data_in(b_data_in), .key(b_key),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .data_out(b_data_out), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One block through the ROUNDS=1 instance with out_ready high.
   task automatic block_a(input logic [15:0] d, input logic [15:0] k,
                          input logic [15:0] exp, input string tag);
      a_data_in  = d;
      a_key      = k;
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      check({tag, " run busy"},     16'(a_busy),      16'd1);
      check({tag, " run in_ready"}, 16'(a_in_ready),  16'd0);
      check({tag, " run ovalid"},   16'(a_out_valid), 16'd0);
      @(negedge clk);
      check({tag, " out_valid"},    16'(a_out_valid), 16'd1);
      check({tag, " data_out"},     a_data_out,       exp);
      check({tag, " done busy"},    16'(a_busy),      16'd0);
      @(negedge clk);
      check({tag, " back idle"},    16'(a_in_ready),  16'd1);
      check({tag, " ovalid low"},   16'(a_out_valid), 16'd0);
   endtask

   initial begin
      rst = 1'b0;
      a_clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_data_in = '0; a_key = '0;
      b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_data_in = '0; b_key = '0;

      // Reset state
      #12;
      check("rst in_ready",  16'(a_in_ready),  16'd1);
      check("rst out_valid", 16'(a_out_valid), 16'd0);
      check("rst busy",      16'(a_busy),      16'd0);
      check("rst data_out",  a_data_out,       16'h0000);
      check("rst b ovalid",  16'(b_out_valid), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Single-round vectors
      block_a(16'h0000, 16'h0000, 16'h9998, "r1 zero");
      block_a(16'hFFFF, 16'hFFFF, 16'h6667, "r1 ones");
      block_a(16'h1234, 16'h0000, 16'hAD73, "r1 data");
      block_a(16'h0000, 16'h1234, 16'h2F35, "r1 key");

      // Two rounds: latency and busy window
      b_data_in = 16'h0000; b_key = 16'h0000; b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      check("r2 c1 busy",   16'(b_busy),      16'd1);
      check("r2 c1 ovalid", 16'(b_out_valid), 16'd0);
      @(negedge clk);
      check("r2 c2 busy",   16'(b_busy),      16'd1);
      check("r2 c2 ovalid", 16'(b_out_valid), 16'd0);
      @(negedge clk);
      check("r2 busy end",  16'(b_busy),      16'd0);
      check("r2 ovalid",    16'(b_out_valid), 16'd1);
      check("r2 data_out",  b_data_out,       16'hFDC5);
      @(negedge clk);
      check("r2 idle",      16'(b_in_ready),  16'd1);

      // Backpressure with in_valid held high throughout
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("bp ovalid",    16'(b_out_valid), 16'd1);
      check("bp data",      b_data_out,       16'hFDC5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp hold data",     b_data_out,       16'hFDC5);
         check("bp hold in_ready", 16'(b_in_ready),  16'd0);
         check("bp hold ovalid",   16'(b_out_valid), 16'd1);
      end
      b_out_ready = 1'b1;
      @(negedge clk);
      check("bp hs in_ready", 16'(b_in_ready),  16'd1);
      check("bp hs busy",     16'(b_busy),      16'd0);
      check("bp hs ovalid",   16'(b_out_valid), 16'd0);
      @(negedge clk);
      check("bp accept busy", 16'(b_busy),      16'd1);
      check("bp accept rdy",  16'(b_in_ready),  16'd0);
      b_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp 2nd data",    b_data_out,       16'hFDC5);
      @(negedge clk);

      // clear in the second RUN cycle with in_valid still high
      b_in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("clr pre busy",   16'(b_busy),      16'd1);
      b_clear = 1'b1;
      @(negedge clk);
      check("clr in_ready",   16'(b_in_ready),  16'd1);
      check("clr busy",       16'(b_busy),      16'd0);
      check("clr ovalid",     16'(b_out_valid), 16'd0);
      check("clr data_out",   b_data_out,       16'h0000);
      b_clear    = 1'b0;
      b_in_valid = 1'b0;
      @(negedge clk);
      check("clr no accept",  16'(b_busy),      16'd0);
      b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("clr fresh data", b_data_out,       16'hFDC5);
      @(negedge clk);

      // Asynchronous reset mid-RUN
      b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      check("arst run busy",  16'(b_busy),      16'd1);
      #2 rst = 1'b0;
      #1;
      check("arst run busy0", 16'(b_busy),      16'd0);
      check("arst run rdy",   16'(b_in_ready),  16'd1);
      check("arst run ov",    16'(b_out_valid), 16'd0);
      check("arst run data",  b_data_out,       16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Asynchronous reset in DONE
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("arst done ov",   16'(b_out_valid), 16'd1);
      #2 rst = 1'b0;
      #1;
      check("arst done ov0",  16'(b_out_valid), 16'd0);
      check("arst done data", b_data_out,       16'h0000);
      check("arst done rdy",  16'(b_in_ready),  16'd1);
      @(negedge clk);
      rst = 1'b1;
      b_out_ready = 1'b1;
      @(negedge clk);

      // Fresh blocks after reset release
      b_data_in = 16'h0000; b_key = 16'h0000; b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post rst ov",    16'(b_out_valid), 16'd1);
      check("post rst data",  b_data_out,       16'h FDC5);
      @(negedge clk);
      block_a(16'hFFFF, 16'hFFFF, 16'h6667, "post rst a");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
